// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// the address width and the sequential instruction step.
package pc_seq_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int INSTR_STEP = 4;

  // Clears the low address bits so every redirect lands on an instruction boundary
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(INSTR_STEP - 1);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DELIVER,
    ERROR
  } pc_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus: the sequencer (master) issues req/addr and
// the memory (slave) returns ack/rdata.
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [PC_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: prioritised, aligned redirect target plus
// the sequential successor. The trap input exists only with PC_SEQ_TRAP_EN.
module pc_next_sel
  import pc_seq_pkg::*;
(
`ifdef PC_SEQ_TRAP_EN
  input  logic                trap,
  input  logic [PC_WIDTH-1:0] trap_vector,
`endif
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic [PC_WIDTH-1:0] cur_pc,
  output logic                redirect,
  output logic [PC_WIDTH-1:0] redirect_target,
  output logic [PC_WIDTH-1:0] seq_pc
);

  logic [PC_WIDTH-1:0] target;

  // Later assignments win, so the highest-priority source is tested last
  always_comb begin
    redirect = 1'b0;
    target   = '0;
    if (branch_taken) begin
      redirect = 1'b1;
      target   = branch_target;
    end
    if (jump) begin
      redirect = 1'b1;
      target   = jump_target;
    end
`ifdef PC_SEQ_TRAP_EN
    if (trap) begin
      redirect = 1'b1;
      target   = trap_vector;
    end
`endif
    redirect_target = target & ALIGN_MASK;
  end

  assign seq_pc = cur_pc + PC_WIDTH'(INSTR_STEP);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: BOOT/FETCH/DELIVER/ERROR FSM with kill handling
// and fetch timeout. Define PC_SEQ_TRAP_EN to add the trap port and TRAP_VECTOR.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
`ifdef PC_SEQ_TRAP_EN
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
`endif
  parameter int unsigned         WAIT_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
`ifdef PC_SEQ_TRAP_EN
  input  logic                trap,
`endif
  pc_sequencer_if.master      imem,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                fetch_err
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

  pc_state_t           state;
  logic                kill;
  logic [PC_WIDTH-1:0] kill_target;
  logic [7:0]          wait_cnt;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_target;
  logic [PC_WIDTH-1:0] seq_pc;

  pc_next_sel u_next_sel (
`ifdef PC_SEQ_TRAP_EN
    .trap            (trap),
    .trap_vector     (TRAP_VECTOR),
`endif
    .jump            (jump),
    .jump_target     (jump_target),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .cur_pc          (instr_pc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .seq_pc          (seq_pc)
  );

  // A redirect seen while a fetch is outstanding cannot cancel the bus
  // transaction, so it is parked in kill/kill_target until the ack arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= BOOT;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= RESET_VECTOR;
      instr_valid    <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
      fetch_err      <= 1'b0;
      kill           <= 1'b0;
      kill_target    <= '0;
      wait_cnt       <= '0;
    end else begin
      case (state)
        BOOT: begin
          state          <= FETCH;
          imem.imem_req  <= 1'b1;
          imem.imem_addr <= RESET_VECTOR;
          wait_cnt       <= '0;
        end
        FETCH: begin
          if (imem.imem_ack) begin
            wait_cnt <= '0;
            if (redirect) begin
              imem.imem_addr <= redirect_target;
              kill           <= 1'b0;
            end else if (kill) begin
              imem.imem_addr <= kill_target;
              kill           <= 1'b0;
            end else begin
              instr         <= imem.imem_rdata;
              instr_pc      <= imem.imem_addr;
              instr_valid   <= 1'b1;
              imem.imem_req <= 1'b0;
              state         <= DELIVER;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state         <= ERROR;
            fetch_err     <= 1'b1;
            imem.imem_req <= 1'b0;
            instr_valid   <= 1'b0;
            kill          <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (redirect) begin
              kill        <= 1'b1;
              kill_target <= redirect_target;
            end
          end
        end
        DELIVER: begin
          if (redirect || !stall) begin
            instr_valid    <= 1'b0;
            imem.imem_req  <= 1'b1;
            imem.imem_addr <= redirect ? redirect_target : seq_pc;
            wait_cnt       <= '0;
            state          <= FETCH;
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer (WAIT_TIMEOUT=16, RESET_VECTOR=0);
// the trap check is built only when PC_SEQ_TRAP_EN is defined.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  typedef struct {
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jump;
    logic [31:0] jumpTarget;
    logic        ack;
    logic [31:0] rdata;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expPc;
    logic        expErr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
`ifdef PC_SEQ_TRAP_EN
  logic        trap;
`endif
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        fetchErr;

  int vecCount  = 0;
  int missCount = 0;

  vec_t vecs[21];

  pc_sequencer_if imemBus ();

  pc_sequencer #(
    .RESET_VECTOR (32'h0000_0000),
`ifdef PC_SEQ_TRAP_EN
    .TRAP_VECTOR  (32'h0000_0100),
`endif
    .WAIT_TIMEOUT (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branchTaken),
    .branch_target (branchTarget),
    .jump          (jump),
    .jump_target   (jumpTarget),
`ifdef PC_SEQ_TRAP_EN
    .trap          (trap),
`endif
    .imem          (imemBus),
    .instr_valid   (instrValid),
    .instr         (instr),
    .instr_pc      (instrPc),
    .fetch_err     (fetchErr)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic st, logic bt, logic [31:0] btg, logic jp, logic [31:0] jtg,
                              logic ak, logic [31:0] rd, logic eReq, logic [31:0] eAddr,
                              logic eV, logic [31:0] eInstr, logic [31:0] ePc, logic eErr);
    vec_t v;
    v.stall = st; v.branchTaken = bt; v.branchTarget = btg; v.jump = jp; v.jumpTarget = jtg;
    v.ack = ak; v.rdata = rd; v.expReq = eReq; v.expAddr = eAddr; v.expValid = eV;
    v.expInstr = eInstr; v.expPc = ePc; v.expErr = eErr;
    return v;
  endfunction

  task automatic applyStimulus(input logic st, input logic bt, input logic [31:0] btg,
                               input logic jp, input logic [31:0] jtg,
                               input logic ak, input logic [31:0] rd);
    stall              = st;
    branchTaken        = bt;
    branchTarget       = btg;
    jump               = jp;
    jumpTarget         = jtg;
    imemBus.imem_ack   = ak;
    imemBus.imem_rdata = rd;
  endtask

  task automatic checkOutput(input string name, input logic eReq, input logic [31:0] eAddr,
                             input logic eV, input logic [31:0] eInstr, input logic [31:0] ePc,
                             input logic eErr);
    vecCount++;
    if (imemBus.imem_req !== eReq || imemBus.imem_addr !== eAddr || instrValid !== eV ||
        instr !== eInstr || instrPc !== ePc || fetchErr !== eErr) begin
      missCount++;
      $display("[TB] FAIL %s: got req=%b addr=%h valid=%b instr=%h pc=%h err=%b, want req=%b addr=%h valid=%b instr=%h pc=%h err=%b",
               name, imemBus.imem_req, imemBus.imem_addr, instrValid, instr, instrPc, fetchErr,
               eReq, eAddr, eV, eInstr, ePc, eErr);
    end
  endtask

  initial begin
    // stall bt  btgt          jmp jtgt          ack rdata         | req addr          v  instr         pc            err
    vecs[0]  = mk(0, 0, 32'h0,   0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0);
    vecs[1]  = mk(0, 0, 32'h0,   0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         0);
    vecs[2]  = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h1111_1111, 1, 32'h0,         0, 32'h0,         32'h0,         0);
    vecs[3]  = mk(0, 0, 32'h0,   0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h1111_1111, 32'h0,         0);
    vecs[4]  = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h2222_2222, 1, 32'h4,         0, 32'h1111_1111, 32'h0,         0);
    vecs[5]  = mk(1, 0, 32'h0,   0, 32'h0,         0, 32'h0,         0, 32'h4,         1, 32'h2222_2222, 32'h4,         0);
    vecs[6]  = mk(1, 0, 32'h0,   0, 32'h0,         1, 32'h9999_9999, 0, 32'h4,         1, 32'h2222_2222, 32'h4,         0);
    vecs[7]  = mk(1, 0, 32'h0,   0, 32'h0,         0, 32'h0,         0, 32'h4,         1, 32'h2222_2222, 32'h4,         0);
    vecs[8]  = mk(0, 0, 32'h0,   0, 32'h0,         0, 32'h0,         0, 32'h4,         1, 32'h2222_2222, 32'h4,         0);
    vecs[9]  = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h3333_3333, 1, 32'h8,         0, 32'h2222_2222, 32'h4,         0);
    vecs[10] = mk(1, 1, 32'h80,  1, 32'h203,       0, 32'h0,         0, 32'h8,         1, 32'h3333_3333, 32'h8,         0);
    vecs[11] = mk(0, 1, 32'h40,  0, 32'h0,         0, 32'h0,         1, 32'h200,       0, 32'h3333_3333, 32'h8,         0);
    vecs[12] = mk(0, 0, 32'h0,   0, 32'h0,         0, 32'h0,         1, 32'h200,       0, 32'h3333_3333, 32'h8,         0);
    vecs[13] = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'hDEAD_BEEF, 1, 32'h200,       0, 32'h3333_3333, 32'h8,         0);
    vecs[14] = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h4444_4444, 1, 32'h40,        0, 32'h3333_3333, 32'h8,         0);
    vecs[15] = mk(0, 0, 32'h0,   1, 32'hFFFF_FFFE, 0, 32'h0,         0, 32'h40,        1, 32'h4444_4444, 32'h40,        0);
    vecs[16] = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h5555_5555, 1, 32'hFFFF_FFFC, 0, 32'h4444_4444, 32'h40,        0);
    vecs[17] = mk(0, 0, 32'h0,   0, 32'h0,         0, 32'h0,         0, 32'hFFFF_FFFC, 1, 32'h5555_5555, 32'hFFFF_FFFC, 0);
    vecs[18] = mk(0, 1, 32'h123, 0, 32'h0,         1, 32'h6666_6666, 1, 32'h0,         0, 32'h5555_5555, 32'hFFFF_FFFC, 0);
    vecs[19] = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h7777_7777, 1, 32'h120,       0, 32'h5555_5555, 32'hFFFF_FFFC, 0);
    vecs[20] = mk(1, 1, 32'h300, 0, 32'h0,         0, 32'h0,         0, 32'h120,       1, 32'h7777_7777, 32'h120,       0);

    reset = 1'b0;
`ifdef PC_SEQ_TRAP_EN
    trap = 1'b0;
`endif
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      checkOutput($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expAddr, vecs[i].expValid,
                  vecs[i].expInstr, vecs[i].expPc, vecs[i].expErr);
      applyStimulus(vecs[i].stall, vecs[i].branchTaken, vecs[i].branchTarget, vecs[i].jump,
                    vecs[i].jumpTarget, vecs[i].ack, vecs[i].rdata);
      @(negedge clk);
    end

    // Fetch at 0x300 never acknowledged: 16 waiting cycles, then ERROR
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("wait%0d", k), 1, 32'h300, 0, 32'h7777_7777, 32'h120, 0);
      @(negedge clk);
    end
    checkOutput("timeout", 0, 32'h300, 0, 32'h7777_7777, 32'h120, 1);
    applyStimulus(0, 1, 32'h80, 1, 32'h40, 1, 32'hABCD_0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("errhold%0d", k), 0, 32'h300, 0, 32'h7777_7777, 32'h120, 1);
    end
    reset = 1'b0;
    #1;
    checkOutput("errreset", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Two redirects while one fetch is outstanding: the later one wins
    checkOutput("boot2", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    checkOutput("kill0", 1, 32'h0, 0, 32'h0, 32'h0, 0);
    applyStimulus(0, 1, 32'h500, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    checkOutput("kill1", 1, 32'h0, 0, 32'h0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 1, 32'h600, 0, 32'h0);
    @(negedge clk);
    checkOutput("kill2", 1, 32'h0, 0, 32'h0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 32'hAAAA_AAAA);
    @(negedge clk);
    checkOutput("kill3", 1, 32'h600, 0, 32'h0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 32'hBBBB_BBBB);
    @(negedge clk);
    checkOutput("kill4", 0, 32'h600, 1, 32'hBBBB_BBBB, 32'h600, 0);

`ifdef PC_SEQ_TRAP_EN
    applyStimulus(1, 0, 32'h0, 1, 32'h40, 0, 32'h0);
    trap = 1'b1;
    @(negedge clk);
    trap = 1'b0;
    checkOutput("trap", 1, 32'h100, 0, 32'hBBBB_BBBB, 32'h600, 0);
`else
    applyStimulus(1, 0, 32'h0, 1, 32'h40, 0, 32'h0);
    @(negedge clk);
    checkOutput("jumpnotrap", 1, 32'h40, 0, 32'hBBBB_BBBB, 32'h600, 0);
`endif

    // Reset asserted with an ack in flight: ack discarded, everything cleared
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 32'hCCCC_CCCC);
    reset = 1'b0;
    #1;
    checkOutput("midreset", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    checkOutput("boot3", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    checkOutput("fetch3", 1, 32'h0, 0, 32'h0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
